// File: rtl/lu_pkg.sv
// lu_pkg - shared definitions for the pipelined logic unit.
//
// Holds the function-select width and the 3-bit op-code constants used by
// lu_func and logic_unit_pipe.
//
// Op-codes:
//   LU_NOT   ~A          LU_XOR   A ^ B
//   LU_NOR   ~(A | B)    LU_XNOR  ~(A ^ B)
//   LU_AND   A & B       LU_NAND  ~(A & B)
//   LU_OR    A | B       LU_NAND2 ~(A & B)  (legacy duplicate encoding)
package lu_pkg;

  localparam int LU_SEL_W = 3;

  typedef enum logic [LU_SEL_W-1:0] {
    LU_NOT   = 3'd0,
    LU_NOR   = 3'd1,
    LU_AND   = 3'd2,
    LU_OR    = 3'd3,
    LU_XOR   = 3'd4,
    LU_XNOR  = 3'd5,
    LU_NAND  = 3'd6,
    LU_NAND2 = 3'd7
  } lu_op_e;

endpackage

// File: rtl/lu_func.sv
// lu_func - purely combinational bitwise function slice.
//
// Parameters:
//   WIDTH   operand/result width in bits
// Ports:
//   a       in   WIDTH      operand A
//   b       in   WIDTH      operand B
//   sel     in   LU_SEL_W   function select (lu_op_e encoding)
//   result  out  WIDTH      selected bitwise function of a and b
module lu_func
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [LU_SEL_W-1:0] sel,
  output logic [WIDTH-1:0]    result
);

  always_comb begin
    result = '0;
    case (sel)
      LU_NOT:   result = ~a;
      LU_NOR:   result = ~(a | b);
      LU_AND:   result = a & b;
      LU_OR:    result = a | b;
      LU_XOR:   result = a ^ b;
      LU_XNOR:  result = ~(a ^ b);
      LU_NAND:  result = ~(a & b);
      LU_NAND2: result = ~(a & b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe - two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides, result flags and an optional accumulator.
//
// Configuration macro:
//   LU_ACCUM_EN  when defined, an internal accumulator can replace operand A
//                (acc_mode) or be read as zero (acc_clr). When undefined,
//                acc_mode/acc_clr are ignored and A is always the input a.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 1)
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input transaction present
//   in_ready   out  1      block accepts input this cycle
//   a, b       in   WIDTH  operands
//   sel        in   3      function select
//   acc_mode   in   1      use the accumulator as A for this transaction
//   acc_clr    in   1      accumulator reads as zero for this transaction
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts result
//   out        out  WIDTH  result
//   zero       out  1      out == 0
//   parity     out  1      XOR-reduction of out
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [LU_SEL_W-1:0] sel,
  input  logic                acc_mode,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic                zero,
  output logic                parity
);

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic [LU_SEL_W-1:0] s1_sel;

  logic                s2_valid;
  logic [WIDTH-1:0]    s2_out;
  logic                s2_zero;
  logic                s2_parity;

  logic                s2_adv;
  logic                in_fire;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    func_result;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle;
  // a full pipeline with out_ready=1 therefore still accepts a new input.
  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire  = in_valid & in_ready;

`ifdef LU_ACCUM_EN
  logic             s1_acc_mode;
  logic             s1_acc_clr;
  logic [WIDTH-1:0] acc;

  always_comb begin
    op_a = s1_a;
    if (s1_acc_mode) begin
      op_a = s1_acc_clr ? '0 : acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc_mode <= 1'b0;
      s1_acc_clr  <= 1'b0;
    end else if (in_fire) begin
      s1_acc_mode <= acc_mode;
      s1_acc_clr  <= acc_clr;
    end
  end

  // acc is read and written at the same S1->S2 transfer, so consecutive
  // accumulate transactions chain without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (s2_adv) begin
      acc <= func_result;
    end
  end
`else
  logic unused_acc_ports;
  assign unused_acc_ports = acc_mode | acc_clr;
  assign op_a             = s1_a;
`endif

  lu_func #(
    .WIDTH (WIDTH)
  ) u_func (
    .a      (op_a),
    .b      (s1_b),
    .sel    (s1_sel),
    .result (func_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_sel   <= sel;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result and flags only load on an S1->S2 transfer, which keeps them
  // stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_out    <= '0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
    end else if (s2_adv) begin
      s2_valid  <= 1'b1;
      s2_out    <= func_result;
      s2_zero   <= (func_result == '0);
      s2_parity <= ^func_result;
    end else if (out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;
  assign zero      = s2_zero;
  assign parity    = s2_parity;

endmodule
